// File: rtl/sum_seq.sv
// Multi-cycle add/subtract unit, CHUNK bits per cycle, LSB first.
// Optional output clamp on signed overflow: SUM_SEQ_SATURATE_EN.
module sum_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             ovf,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    WORK
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] res;
  logic [CHUNK:0]   sum;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             a_msb;
  logic             b_msb;
  logic             accept;
  logic             last;
  logic             ovf_nx;

  assign ready  = (state == IDLE);
  assign busy   = !ready;
  assign accept = start && ready;
  assign last   = (cnt == CW'(N - 1));

  assign sum = {1'b0, opa[CHUNK-1:0]}
             + {1'b0, opb[CHUNK-1:0]}
             + {{CHUNK{1'b0}}, c};

  // new chunk enters at the top; after N steps acc holds the full result
  assign acc_nx = (acc >> CHUNK)
                | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  assign ovf_nx = (a_msb == b_msb)
               && (acc_nx[WIDTH-1] != a_msb);

`ifdef SUM_SEQ_SATURATE_EN
  always_comb begin
    res = acc_nx;
    if (ovf_nx) begin
      res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                  : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res = acc_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = WORK;
      WORK: if (last)   state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      c     <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
      y     <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        opa   <= a;
        opb   <= sub ? ~b : b;
        c     <= sub;
        a_msb <= a[WIDTH-1];
        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        acc   <= '0;
        cnt   <= '0;
      end else if (state == WORK) begin
        opa <= opa >> CHUNK;
        opb <= opb >> CHUNK;
        c   <= sum[CHUNK];
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          y     <= res;
          carry <= sum[CHUNK];
          ovf   <= ovf_nx;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_seq.sv
// Directed bench for sum_seq, WIDTH=16 CHUNK=4.
// Define SUM_SEQ_SATURATE_EN here too when building the clamped variant.
module tb_sum_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready;
  logic        busy;
  logic [15:0] y;
  logic        carry;
  logic        ovf;
  logic        done;

  int total = 0;
  int bad = 0;

  sum_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sub(sub), .a(a), .b(b), .ready(ready),
    .busy(busy), .y(y), .carry(carry),
    .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // accept one op, count busy cycles, check the completion values
  task automatic do_op(input string tag,
                       input logic [15:0] va,
                       input logic [15:0] vb,
                       input logic        vs,
                       input logic [15:0] ey,
                       input logic        ec,
                       input logic        eo);
    int n;
    int nb;
    @(negedge clk);
    a = va; b = vb; sub = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~va; b = ~vb; sub = ~vs;
    n = 0; nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_busy"}, nb, 4);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_c"}, carry, ec);
    chk({tag, "_o"}, ovf, eo);
    chk({tag, "_rdy"}, ready, 1);
    @(posedge clk); #1;
    chk({tag, "_dlo"}, done, 0);
    chk({tag, "_hold"}, y, ey);
  endtask

  logic [15:0] q[$];
  int acc_cyc[$];
  int ndone;
  int n;

  initial begin
    #1;
    chk("rst_y", y, 16'h0000);
    chk("rst_rdy", {ready, busy, done}, 3'b100);
    #20;
    rst_n = 1'b1;

    do_op("add1", 16'h1234, 16'h1111, 0, 16'h2345, 0, 0);
    do_op("addw", 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
    do_op("sub1", 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0);
`ifdef SUM_SEQ_SATURATE_EN
    do_op("ovfa", 16'h7FFF, 16'h0001, 0, 16'h7FFF, 0, 1);
    do_op("ovfs", 16'h8000, 16'h0001, 1, 16'h8000, 1, 1);
`else
    do_op("ovfa", 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    do_op("ovfs", 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1);
`endif
    do_op("sub2", 16'h1000, 16'h0001, 1, 16'h0FFF, 1, 0);

    // reset in idle clears held outputs at once
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("idle_rst_y", y, 16'h0000);
    chk("idle_rst_f", {carry, ovf, done, ready, busy}, 5'b00010);
    @(negedge clk);
    rst_n = 1'b1;

    // start pulses while busy are ignored
    @(negedge clk);
    a = 16'h0100; b = 16'h0023; sub = 0; start = 1'b1;
    @(negedge clk);
    a = 16'h5555; b = 16'h5555;
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      start = (i != 1);
      @(posedge clk); #1;
      if (done) ndone++;
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("busy_start_y", y, 16'h0123);
    chk("busy_start_nd", ndone, 1);

    // start held high, operands changing every cycle
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      a = 16'(cyc) * 16'h0101;
      b = 16'h0011 + 16'(cyc);
      sub = 0;
      start = 1'b1;
      if (ready) begin
        q.push_back(a + b);
        acc_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (q.size() > 0) chk("b2b_y", y, q.pop_front());
        else chk("b2b_extra", 1, 0);
      end
    end
    start = 1'b0;
    chk("b2b_acc", acc_cyc.size(), 4);
    chk("b2b_done", ndone, 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 5);

    // reset after the second WORK edge discards the op
    @(negedge clk);
    a = 16'h4444; b = 16'h1111; sub = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y", y, 16'h0000);
    chk("mid_rst_f", {done, ready, busy}, 3'b010);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("mid_rst_nd", n, 0);
    do_op("post", 16'h0001, 16'h0002, 0, 16'h0003, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
